// File: rtl/sam_pkg.sv
// ---------------------------------------------------------------------------
// sam_pkg
// Shared definitions for the SAM serial link (transmitter and receiver).
//   - samState_t      : transmitter state encoding
//   - SAM_MAX_N       : largest legal key width exponent (width = 2^n)
//   - SAM_KEY_W       : width of the key registers d and capsN
//   - SAM_SYM_LEN_MIN/MAX : legal range of clocks per data symbol
//   - keyTopIdx()     : index of the first key bit sent, (1<<n)-1 at 6 bits
// Optional feature macro: SAM_TX_PARITY_EN adds the PAR state.
// ---------------------------------------------------------------------------
package sam_pkg;

  localparam int SAM_MAX_N       = 5;
  localparam int SAM_KEY_W       = 32;
  localparam int SAM_SYM_LEN_MIN = 10;
  localparam int SAM_SYM_LEN_MAX = 60;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG_N = 3'd1,
    ST_CFG_D = 3'd2,
    ST_CFG_C = 3'd3,
    ST_PRE   = 3'd4,
    ST_DATA  = 3'd5,
`ifdef SAM_TX_PARITY_EN
    ST_PAR   = 3'd6,
`endif
    ST_TAIL  = 3'd7
  } samState_t;

  // Computed at 6 bits so that n = 5 yields 31 without wrapping.
  function automatic logic [5:0] keyTopIdx(input logic [3:0] n);
    logic [5:0] one;
    one = 6'd1;
    return (one << n) - 6'd1;
  endfunction

endpackage

// File: rtl/sam_tx_if.sv
// ---------------------------------------------------------------------------
// sam_tx_if
// Bundles the key/configuration inputs, the valid/ready message bit stream
// and the serial/status outputs of sam_tx.
//   master : message/key source side (drives cfg_* and bit_*)
//   slave  : sam_tx side (drives bit_ready, str, mode, busy, done,
//            cfg_err, underrun)
// ---------------------------------------------------------------------------
interface sam_tx_if;
  import sam_pkg::*;

  logic [3:0]           cfg_n;
  logic [SAM_KEY_W-1:0] cfg_d;
  logic [SAM_KEY_W-1:0] cfg_caps;
  logic                 cfg_start;
  logic                 bit_data;
  logic                 bit_valid;
  logic                 bit_last;
  logic                 bit_ready;
  logic                 str;
  logic                 mode;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;
  logic                 underrun;

  modport master (
    output cfg_n, cfg_d, cfg_caps, cfg_start, bit_data, bit_valid, bit_last,
    input  bit_ready, str, mode, busy, done, cfg_err, underrun
  );

  modport slave (
    input  cfg_n, cfg_d, cfg_caps, cfg_start, bit_data, bit_valid, bit_last,
    output bit_ready, str, mode, busy, done, cfg_err, underrun
  );

endinterface

// File: rtl/sam_sym_gen.sv
// ---------------------------------------------------------------------------
// sam_sym_gen
// Run-length symbol generator. Owns the 6-bit symbol counter, which counts
// SYM_LEN-1 down to 0 and then holds at 0.
//   clk, reset  : clock, asynchronous active-high reset
//   i_start     : load the counter and latch i_bit (symbol begins next clock)
//   i_bit       : value of the symbol being started
//   o_last      : current clock is the final clock of the symbol
//   o_strNxt    : str pattern value for the next clock (ones first, then
//                 zeros: bit 1 = SYM_LEN-2 ones, bit 0 = 2 ones)
//   o_lastNxt   : next clock will be the final clock of the symbol
// The *Nxt outputs let the parent register its outputs in step with the
// counter instead of decoding them after the flops.
// ---------------------------------------------------------------------------
module sam_sym_gen #(
  parameter int SYM_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_bit,
  output logic o_last,
  output logic o_strNxt,
  output logic o_lastNxt
);

  localparam logic [5:0] LP_CNT_TOP  = 6'(SYM_LEN - 1);
  localparam logic [5:0] LP_ZERO_ONE = 6'(SYM_LEN - 2);

  logic [5:0] r_cnt;
  logic       r_bit;
  logic [5:0] w_cntNxt;
  logic       w_bitNxt;

  always_comb begin
    w_cntNxt = r_cnt;
    w_bitNxt = r_bit;
    if (i_start) begin
      w_cntNxt = LP_CNT_TOP;
      w_bitNxt = i_bit;
    end else if (r_cnt != 6'd0) begin
      w_cntNxt = r_cnt - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 6'd0;
      r_bit <= 1'b0;
    end else begin
      r_cnt <= w_cntNxt;
      r_bit <= w_bitNxt;
    end
  end

  assign o_last    = (r_cnt == 6'd0);
  assign o_lastNxt = (w_cntNxt == 6'd0);
  // Counting down: the ones occupy the high counter values.
  assign o_strNxt  = w_bitNxt ? (w_cntNxt >= 6'd2) : (w_cntNxt >= LP_ZERO_ONE);

endmodule

// File: rtl/sam_tx.sv
// ---------------------------------------------------------------------------
// sam_tx
// Serial encoder feeding the SAM decryption receiver. A start command shifts
// out n (4 bits), d and capsN (2^n bits each, MSB first) with mode high,
// then a preamble bit-0 symbol and one run-length symbol per message bit,
// then TAIL_LEN clocks of ones with a done pulse on the last one.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sam_tx_if.slave (cfg_*, bit_* handshake, str/mode/status)
// Parameters: SYM_LEN (10..60) clocks per symbol, TAIL_LEN (>=1) tail clocks.
// Optional feature macro: SAM_TX_PARITY_EN appends an even-parity symbol
// after the last message bit.
// All outputs come straight from flops; the next-state logic computes the
// values for the coming clock.
// ---------------------------------------------------------------------------
module sam_tx
  import sam_pkg::*;
#(
  parameter int SYM_LEN  = 16,
  parameter int TAIL_LEN = 4
) (
  input  logic    clk,
  input  logic    reset,
  sam_tx_if.slave bus
);

  localparam int             TW          = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [TW-1:0]  LP_TAIL_TOP = TW'(TAIL_LEN - 1);
  localparam logic [TW-1:0]  LP_TAIL_ONE = TW'(1);

  samState_t            r_state, w_stateNxt;
  logic [5:0]           r_idx, w_idxNxt;
  logic [TW-1:0]        r_tailCnt, w_tailNxt;
  logic [3:0]           r_n, w_nNxt;
  logic [SAM_KEY_W-1:0] r_d, w_dNxt;
  logic [SAM_KEY_W-1:0] r_caps, w_capsNxt;
  logic                 r_lastBit, w_lastBitNxt;
  logic                 r_underFlag, w_underFlagNxt;
`ifdef SAM_TX_PARITY_EN
  logic                 r_par, w_parNxt;
`endif

  logic r_str, r_mode, r_busy, r_ready, r_done, r_cfgErr, r_underrun;
  logic w_strNxt, w_modeNxt, w_busyNxt, w_readyNxt, w_doneNxt, w_cfgErrNxt, w_underrunNxt;

  logic w_symStart, w_symBit, w_symLast, w_symStrNxt, w_symLastNxt;

  sam_sym_gen #(.SYM_LEN(SYM_LEN)) u_symGen (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_symStart),
    .i_bit     (w_symBit),
    .o_last    (w_symLast),
    .o_strNxt  (w_symStrNxt),
    .o_lastNxt (w_symLastNxt)
  );

  // Next-state logic. The bit handshake is taken on the final clock of a
  // PRE/DATA symbol, where bit_ready is high unless the last bit was sent.
  always_comb begin
    w_stateNxt     = r_state;
    w_idxNxt       = r_idx;
    w_tailNxt      = r_tailCnt;
    w_nNxt         = r_n;
    w_dNxt         = r_d;
    w_capsNxt      = r_caps;
    w_lastBitNxt   = r_lastBit;
    w_underFlagNxt = r_underFlag;
`ifdef SAM_TX_PARITY_EN
    w_parNxt       = r_par;
`endif
    w_symStart     = 1'b0;
    w_symBit       = 1'b0;
    w_cfgErrNxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          if (bus.cfg_n <= 4'(SAM_MAX_N)) begin
            w_stateNxt     = ST_CFG_N;
            w_idxNxt       = 6'd3;
            w_nNxt         = bus.cfg_n;
            w_dNxt         = bus.cfg_d;
            w_capsNxt      = bus.cfg_caps;
            w_lastBitNxt   = 1'b0;
            w_underFlagNxt = 1'b0;
`ifdef SAM_TX_PARITY_EN
            w_parNxt       = 1'b0;
`endif
          end else begin
            w_cfgErrNxt = 1'b1;
          end
        end
      end
      ST_CFG_N: begin
        if (r_idx == 6'd0) begin
          w_stateNxt = ST_CFG_D;
          w_idxNxt   = keyTopIdx(r_n);
        end else begin
          w_idxNxt = r_idx - 6'd1;
        end
      end
      ST_CFG_D: begin
        if (r_idx == 6'd0) begin
          w_stateNxt = ST_CFG_C;
          w_idxNxt   = keyTopIdx(r_n);
        end else begin
          w_idxNxt = r_idx - 6'd1;
        end
      end
      ST_CFG_C: begin
        if (r_idx == 6'd0) begin
          w_stateNxt = ST_PRE;
          w_symStart = 1'b1;
          w_symBit   = 1'b0;
        end else begin
          w_idxNxt = r_idx - 6'd1;
        end
      end
      ST_PRE, ST_DATA: begin
        if (w_symLast) begin
          if (r_ready) begin
            if (bus.bit_valid) begin
              w_stateNxt   = ST_DATA;
              w_symStart   = 1'b1;
              w_symBit     = bus.bit_data;
              w_lastBitNxt = bus.bit_last;
`ifdef SAM_TX_PARITY_EN
              w_parNxt     = r_par ^ bus.bit_data;
`endif
            end else begin
              w_stateNxt     = ST_TAIL;
              w_tailNxt      = LP_TAIL_TOP;
              w_underFlagNxt = 1'b1;
            end
          end else begin
`ifdef SAM_TX_PARITY_EN
            w_stateNxt = ST_PAR;
            w_symStart = 1'b1;
            w_symBit   = r_par;
`else
            w_stateNxt = ST_TAIL;
            w_tailNxt  = LP_TAIL_TOP;
`endif
          end
        end
      end
`ifdef SAM_TX_PARITY_EN
      ST_PAR: begin
        if (w_symLast) begin
          w_stateNxt = ST_TAIL;
          w_tailNxt  = LP_TAIL_TOP;
        end
      end
`endif
      ST_TAIL: begin
        if (r_tailCnt == '0) begin
          w_stateNxt = ST_IDLE;
        end else begin
          w_tailNxt = r_tailCnt - LP_TAIL_ONE;
        end
      end
      default: w_stateNxt = ST_IDLE;
    endcase
  end

  // Output values for the coming clock, derived from the next state so the
  // registered outputs line up exactly with the state they describe.
  always_comb begin
    w_strNxt = 1'b1;
    case (w_stateNxt)
      ST_CFG_N: w_strNxt = w_nNxt[w_idxNxt[1:0]];
      ST_CFG_D: w_strNxt = w_dNxt[w_idxNxt[4:0]];
      ST_CFG_C: w_strNxt = w_capsNxt[w_idxNxt[4:0]];
      ST_PRE, ST_DATA: w_strNxt = w_symStrNxt;
`ifdef SAM_TX_PARITY_EN
      ST_PAR: w_strNxt = w_symStrNxt;
`endif
      default: w_strNxt = 1'b1;
    endcase
    w_modeNxt     = (w_stateNxt == ST_CFG_N) || (w_stateNxt == ST_CFG_D) ||
                    (w_stateNxt == ST_CFG_C);
    w_busyNxt     = (w_stateNxt != ST_IDLE);
    w_readyNxt    = ((w_stateNxt == ST_PRE) || (w_stateNxt == ST_DATA)) &&
                    w_symLastNxt && !w_lastBitNxt;
    w_doneNxt     = (w_stateNxt == ST_TAIL) && (w_tailNxt == '0);
    w_underrunNxt = w_doneNxt && w_underFlagNxt;
  end

  // State, counters, latched key and output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 6'd0;
      r_tailCnt   <= '0;
      r_n         <= 4'd0;
      r_d         <= '0;
      r_caps      <= '0;
      r_lastBit   <= 1'b0;
      r_underFlag <= 1'b0;
`ifdef SAM_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
      r_str       <= 1'b1;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_cfgErr    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_idx       <= w_idxNxt;
      r_tailCnt   <= w_tailNxt;
      r_n         <= w_nNxt;
      r_d         <= w_dNxt;
      r_caps      <= w_capsNxt;
      r_lastBit   <= w_lastBitNxt;
      r_underFlag <= w_underFlagNxt;
`ifdef SAM_TX_PARITY_EN
      r_par       <= w_parNxt;
`endif
      r_str       <= w_strNxt;
      r_mode      <= w_modeNxt;
      r_busy      <= w_busyNxt;
      r_ready     <= w_readyNxt;
      r_done      <= w_doneNxt;
      r_cfgErr    <= w_cfgErrNxt;
      r_underrun  <= w_underrunNxt;
    end
  end

  assign bus.str       = r_str;
  assign bus.mode      = r_mode;
  assign bus.busy      = r_busy;
  assign bus.bit_ready = r_ready;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfgErr;
  assign bus.underrun  = r_underrun;

endmodule

// File: tb/tb_sam_tx.sv
// ---------------------------------------------------------------------------
// tb_sam_tx
// Directed bench for sam_tx. Each transaction pushes the expected per-clock
// {str, mode, done, underrun} samples into a scoreboard queue; every busy
// clock pops one sample and compares. A bit source feeds the valid/ready
// interface from a second queue and scrambles bit_data/bit_last whenever
// bit_ready is low.
// ---------------------------------------------------------------------------
module tb_sam_tx;
  import sam_pkg::*;

  localparam int SYM = 16;
  localparam int TL  = 4;

  typedef struct packed {
    logic str;
    logic mode;
    logic done;
    logic under;
  } expSample_t;

  logic clk = 1'b0;
  logic reset;

  sam_tx_if bus ();

  sam_tx #(.SYM_LEN(SYM), .TAIL_LEN(TL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  expSample_t expQ[$];
  logic [1:0] bitQ[$];
  int         nTests     = 0;
  int         nFail      = 0;
  int         busyCycles = 0;
  int         expLen     = 0;
  int         sampleIdx  = 0;
  bit         takePending = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock step: at the falling edge compare the scoreboard against the
  // DUT while busy, then update the bit source for the next rising edge.
  task automatic tick();
    expSample_t s;
    @(negedge clk);
    if (bus.busy === 1'b1) begin
      busyCycles++;
      checkOutput($sformatf("expQueue@%0d", sampleIdx), 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        s = expQ.pop_front();
        checkOutput($sformatf("stream@%0d", sampleIdx),
                    {28'd0, bus.str, bus.mode, bus.done, bus.underrun}, {28'd0, s});
      end
      sampleIdx++;
    end
    if (takePending) begin
      bitQ.delete(0);
      takePending = 1'b0;
    end
    if (bitQ.size() > 0 && bus.bit_ready === 1'b1) begin
      bus.bit_valid = 1'b1;
      bus.bit_data  = bitQ[0][0];
      bus.bit_last  = bitQ[0][1];
      takePending   = 1'b1;
    end else begin
      bus.bit_valid = (bitQ.size() > 0);
      bus.bit_data  = 1'($urandom);
      bus.bit_last  = 1'($urandom);
    end
  endtask

  task automatic pushSym(input logic b);
    expSample_t s;
    for (int k = 0; k < SYM; k++) begin
      s.str   = b ? (k < SYM - 2) : (k < 2);
      s.mode  = 1'b0;
      s.done  = 1'b0;
      s.under = 1'b0;
      expQ.push_back(s);
    end
  endtask

  // Build the expected stream and bit queue, then pulse cfg_start.
  // lastIdx < 0 means no bit is flagged last, so the stream ends in underrun.
  task automatic applyStimulus(input logic [3:0] n, input logic [31:0] d, input logic [31:0] c,
                               input logic [15:0] bits, input int nbits, input int lastIdx);
    expSample_t s;
    int   width;
    logic parity;
    logic under;
    width  = 1 << n;
    parity = 1'b0;
    under  = (lastIdx < 0);
    s.mode = 1'b1; s.done = 1'b0; s.under = 1'b0;
    for (int i = 3; i >= 0; i--) begin s.str = n[i]; expQ.push_back(s); end
    for (int i = width - 1; i >= 0; i--) begin s.str = d[i]; expQ.push_back(s); end
    for (int i = width - 1; i >= 0; i--) begin s.str = c[i]; expQ.push_back(s); end
    pushSym(1'b0);
    for (int i = 0; i < nbits; i++) begin
      pushSym(bits[i]);
      parity ^= bits[i];
      bitQ.push_back({(i == lastIdx), bits[i]});
    end
    expLen = 4 + 2 * width + SYM * (nbits + 1) + TL;
`ifdef SAM_TX_PARITY_EN
    if (!under) begin
      pushSym(parity);
      expLen += SYM;
    end
`endif
    for (int t = 0; t < TL; t++) begin
      s.str = 1'b1; s.mode = 1'b0;
      s.done = (t == TL - 1);
      s.under = (t == TL - 1) && under;
      expQ.push_back(s);
    end
    busyCycles    = 0;
    sampleIdx     = 0;
    bus.cfg_n     = n;
    bus.cfg_d     = d;
    bus.cfg_caps  = c;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Run until the scoreboard drains and busy drops (bounded), then check
  // length and idle outputs.
  task automatic waitDone(input string tag);
    for (int i = 0; i < 3000 && (expQ.size() != 0 || bus.busy === 1'b1); i++) tick();
    checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_len"}, 32'(busyCycles), 32'(expLen));
    checkOutput({tag, "_bitsLeft"}, 32'(bitQ.size()), 32'd0);
    checkOutput({tag, "_idle"},
                {26'd0, bus.str, bus.mode, bus.busy, bus.done, bus.underrun, bus.bit_ready},
                32'b100000);
  endtask

  // Directed sequence.
  initial begin
    logic [15:0] rb;
    reset         = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_n     = 4'd0;
    bus.cfg_d     = '0;
    bus.cfg_caps  = '0;
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    bus.bit_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_str",      32'(bus.str),       32'd1);
    checkOutput("rst_mode",     32'(bus.mode),      32'd0);
    checkOutput("rst_busy",     32'(bus.busy),      32'd0);
    checkOutput("rst_ready",    32'(bus.bit_ready), 32'd0);
    checkOutput("rst_done",     32'(bus.done),      32'd0);
    checkOutput("rst_cfgErr",   32'(bus.cfg_err),   32'd0);
    checkOutput("rst_underrun", 32'(bus.underrun),  32'd0);
    reset = 1'b0;
    tick();

    // Rejected key width.
    bus.cfg_n = 4'd7; bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    checkOutput("err_pulse", 32'(bus.cfg_err), 32'd1);
    checkOutput("err_busy",  32'(bus.busy),    32'd0);
    checkOutput("err_str",   32'(bus.str),     32'd1);
    tick();
    checkOutput("err_clear", 32'(bus.cfg_err), 32'd0);
    checkOutput("err_busy2", 32'(bus.busy),    32'd0);

    // n=2, d=0xA, caps=0x3, bits 1,0,1 with last on the third.
    applyStimulus(4'd2, 32'hA, 32'h3, 16'b101, 3, 2);
    waitDone("txA");

    // Underrun at the first ready clock, n=0.
    applyStimulus(4'd0, 32'h1, 32'h0, 16'b0, 0, -1);
    waitDone("under0");

    // Underrun after one accepted bit, n=1.
    applyStimulus(4'd1, 32'h2, 32'h1, 16'b1, 1, -1);
    waitDone("under1");

    // Reset in the middle of CFG_D, then replay with bits 1,1,0 (last).
    applyStimulus(4'd5, 32'hDEADBEEF, 32'h12345678, 16'b0, 0, -1);
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("midRst_str",   32'(bus.str),       32'd1);
    checkOutput("midRst_mode",  32'(bus.mode),      32'd0);
    checkOutput("midRst_busy",  32'(bus.busy),      32'd0);
    checkOutput("midRst_ready", 32'(bus.bit_ready), 32'd0);
    expQ.delete();
    bitQ.delete();
    takePending = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(4'd5, 32'h80000001, 32'h7FFFFFFE, 16'b011, 3, 2);
    repeat (3) tick();
    // A start during the configuration phase must be ignored.
    bus.cfg_n = 4'd3; bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    waitDone("replay");

    // Bits 1,0,0 (last), n=1.
    applyStimulus(4'd1, 32'h2, 32'h1, 16'b001, 3, 2);
    waitDone("txB");

    // Eight random bits, n=3.
    rb = 16'($urandom);
    applyStimulus(4'd3, $urandom, $urandom, rb, 8, 7);
    waitDone("txRand");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
